multi_counter: RTL and testbench
================================

MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 Parameter WIDTH, default 64: width of each channel count.
REQ-002 Parameter SEL_W, default 2: select width; channel count CH = 2**SEL_W.
REQ-003 Parameter PRE_W, default 8: width of each channel prescale divisor.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset; Reset==0 at a rising Clk edge resets the block.
REQ-006 Slt  input  SEL_W  channel select for En, CfgWe and Clr.
REQ-007 En  input  1  count enable for the selected channel.
REQ-008 CfgWe  input  1  write CfgDiv into the selected channel's divisor.
REQ-009 CfgDiv  input  PRE_W  divisor value; channel increments once per (CfgDiv+1) enabled cycles.
REQ-010 Clr  input  1  clear the selected channel.
REQ-011 Count  output  CH*WIDTH  packed registered counts; channel k at bits [k*WIDTH +: WIDTH].
REQ-012 Tick  output  CH  registered one-cycle pulse; bit k high in the cycle after the edge where Count k changed by +1.
REQ-013 Wrap  output  CH  registered sticky flag per channel (overflow or saturation, see REQ-024/025).

Function
REQ-014 Each channel k SHALL hold div_k (PRE_W), pre_k (PRE_W), Count k, Wrap k.
REQ-015 Only channel Slt SHALL be affected by En, CfgWe, Clr; all other channels hold state.
REQ-016 Per-edge priority for selected channel: Clr > CfgWe > En.
REQ-017 Clr: Count k, pre_k, Wrap k <= 0; div_k unchanged; Tick k = 0 next cycle.
REQ-018 CfgWe (no Clr): div_k <= CfgDiv, pre_k <= 0, Count k unchanged, no increment that edge.
REQ-019 En (no Clr/CfgWe): if pre_k == div_k then pre_k <= 0 and Count k increments; else pre_k <= pre_k + 1, Count k holds.
REQ-020 With div_k = 0 the channel SHALL increment on every enabled cycle; with div_k = 3, on the 4th, 8th, ... enabled cycle.
REQ-021 En low, or channel not selected: pre_k and Count k hold; prescale phase is preserved across pauses and select changes.
REQ-022 Tick k SHALL be high for exactly one cycle per increment; never high without a Count change.
REQ-023 Count arithmetic modulo 2**WIDTH; no carry between channels.
REQ-024 Count at all-ones plus an increment (wrap mode) SHALL become 0 and set Wrap k.
REQ-025 Wrap k SHALL stay set until Clr of channel k or reset.

Reset
REQ-026 On Reset==0: all Count, pre_k, div_k, Tick, Wrap SHALL be 0, regardless of En/CfgWe/Clr.
REQ-027 Reset mid-prescale SHALL discard phase; first post-reset increment follows the full (div_k+1) enabled-cycle sequence with div_k = 0.

Configuration
REQ-028 Macro MULTI_COUNTER_SAT_EN SHALL select overflow behaviour at compile time.
REQ-029 Defined: Count k saturates at all-ones; Wrap k set on the edge Count k reaches all-ones; further increments hold Count, Tick k stays 0; prescaler keeps cycling.
REQ-030 Undefined: wrap behaviour per REQ-024.

Verification
REQ-031 Reset low 2 cycles, then En=1, Slt=0, 5 cycles -> Count0 = 5, Tick0 high 5 cycles, Count1..3 = 0.
REQ-032 CfgWe=1, Slt=1, CfgDiv=3; then En=1 for 8 cycles -> Count1 = 2, Tick1 pulses after enabled cycles 4 and 8 only.
REQ-033 WIDTH=8, channel 2 driven to 255 then one increment -> no macro: Count2 = 0, Wrap2 = 1; with MULTI_COUNTER_SAT_EN: Count2 = 255, Wrap2 = 1 from reaching 255, Tick2 = 0.
REQ-034 Clr, CfgWe, En all high, Slt=3, Count3 = 7 -> Count3 = 0, div_3 unchanged, Wrap3 = 0, no Tick3.
REQ-035 Channel 1 div=3, 2 enabled cycles, switch Slt to 0 for 10 cycles, back to 1 for 2 cycles -> Count1 increments once at 4th channel-1 cycle; Count0 = 10.
REQ-036 Reset low mid-prescale (pre_1 = 2, Count1 = 9) -> all outputs 0 next cycle, div_1 = 0.

Source files
------------

// File: rtl/multi_counter_if.sv
// rtl/multi_counter_if.sv - Control and status bundle for multi_counter.
interface multi_counter_if #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 2,
  parameter int PRE_W = 8
);
  localparam int CH = 2 ** SEL_W;

  logic [SEL_W-1:0]    Slt;
  logic                En;
  logic                CfgWe;
  logic [PRE_W-1:0]    CfgDiv;
  logic                Clr;
  logic [CH*WIDTH-1:0] Count;
  logic [CH-1:0]       Tick;
  logic [CH-1:0]       Wrap;

  modport master (
    output Slt, En, CfgWe, CfgDiv, Clr,
    input  Count, Tick, Wrap
  );

  modport slave (
    input  Slt, En, CfgWe, CfgDiv, Clr,
    output Count, Tick, Wrap
  );
endinterface

// File: rtl/multi_counter.sv
// rtl/multi_counter.sv - CH independent prescaled counters sharing one select/command port.
// Define MULTI_COUNTER_SAT_EN to saturate counts at all-ones instead of wrapping.
module multi_counter #(
  parameter int WIDTH = 64,
  parameter int SEL_W = 2,
  parameter int PRE_W = 8
) (
  input logic              Clk,
  input logic              Reset,
  multi_counter_if.slave   bus
);
  localparam int CH = 2 ** SEL_W;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0]    count_q [CH];
  logic [WIDTH-1:0]    count_d [CH];
  logic [PRE_W-1:0]    pre_q   [CH];
  logic [PRE_W-1:0]    pre_d   [CH];
  logic [PRE_W-1:0]    div_q   [CH];
  logic [PRE_W-1:0]    div_d   [CH];
  logic [CH-1:0]       tick_q, tick_d;
  logic [CH-1:0]       wrap_q, wrap_d;
  logic [CH*WIDTH-1:0] count_flat;

  always_comb begin
    tick_d = '0;
    wrap_d = wrap_q;
    for (int k = 0; k < CH; k++) begin
      count_d[k] = count_q[k];
      pre_d[k]   = pre_q[k];
      div_d[k]   = div_q[k];
      // Unselected channels fall through with all state held, preserving prescale phase.
      if (bus.Slt == SEL_W'(k)) begin
        if (bus.Clr) begin
          count_d[k] = '0;
          pre_d[k]   = '0;
          wrap_d[k]  = 1'b0;
        end else if (bus.CfgWe) begin
          div_d[k] = bus.CfgDiv;
          pre_d[k] = '0;
        end else if (bus.En) begin
          if (pre_q[k] == div_q[k]) begin
            pre_d[k] = '0;
`ifdef MULTI_COUNTER_SAT_EN
            if (count_q[k] != ALL_ONES) begin
              count_d[k] = count_q[k] + WIDTH'(1);
              tick_d[k]  = 1'b1;
              if (count_q[k] == ALL_ONES - WIDTH'(1)) begin
                wrap_d[k] = 1'b1;
              end
            end
`else
            count_d[k] = count_q[k] + WIDTH'(1);
            tick_d[k]  = 1'b1;
            if (count_q[k] == ALL_ONES) begin
              wrap_d[k] = 1'b1;
            end
`endif
          end else begin
            pre_d[k] = pre_q[k] + PRE_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int k = 0; k < CH; k++) begin
        count_q[k] <= '0;
        pre_q[k]   <= '0;
        div_q[k]   <= '0;
      end
      tick_q <= '0;
      wrap_q <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        count_q[k] <= count_d[k];
        pre_q[k]   <= pre_d[k];
        div_q[k]   <= div_d[k];
      end
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    count_flat = '0;
    for (int k = 0; k < CH; k++) begin
      count_flat[k*WIDTH +: WIDTH] = count_q[k];
    end
  end

  assign bus.Count = count_flat;
  assign bus.Tick  = tick_q;
  assign bus.Wrap  = wrap_q;
endmodule

// File: tb/tb_multi_counter.sv
// tb/tb_multi_counter.sv - Randomized and directed bench for multi_counter against an event-count model.
module tb_multi_counter;
  localparam int WIDTH = 8;
  localparam int SEL_W = 2;
  localparam int PRE_W = 8;
  localparam int CH    = 2 ** SEL_W;
  localparam longint MAXV = (64'd1 << WIDTH) - 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  multi_counter_if #(.WIDTH(WIDTH), .SEL_W(SEL_W), .PRE_W(PRE_W)) bus ();

  multi_counter #(.WIDTH(WIDTH), .SEL_W(SEL_W), .PRE_W(PRE_W)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: total increments since clear, and enabled cycles since the phase was last restarted.
  longint m_inc  [CH];
  int     m_en   [CH];
  int     m_div  [CH];
  bit     m_tick [CH];
  bit     model_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_cnt(int k);
`ifdef MULTI_COUNTER_SAT_EN
    return (m_inc[k] >= MAXV) ? 64'(MAXV) : 64'(m_inc[k]);
`else
    return 64'(m_inc[k] % (MAXV + 1));
`endif
  endfunction

  function automatic logic [63:0] exp_wrap(int k);
`ifdef MULTI_COUNTER_SAT_EN
    return {63'd0, m_inc[k] >= MAXV};
`else
    return {63'd0, m_inc[k] > MAXV};
`endif
  endfunction

  always @(posedge clk) begin
    int k;
    for (int i = 0; i < CH; i++) m_tick[i] = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_inc[i] = 0;
        m_en[i]  = 0;
        m_div[i] = 0;
      end
      model_on = 1'b1;
    end else if (model_on) begin
      k = int'(bus.Slt);
      if (bus.Clr) begin
        m_inc[k] = 0;
        m_en[k]  = 0;
      end else if (bus.CfgWe) begin
        m_div[k] = int'(bus.CfgDiv);
        m_en[k]  = 0;
      end else if (bus.En) begin
        m_en[k]++;
        if (m_en[k] % (m_div[k] + 1) == 0) begin
          m_inc[k]++;
`ifdef MULTI_COUNTER_SAT_EN
          m_tick[k] = (m_inc[k] <= MAXV);
`else
          m_tick[k] = 1'b1;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < CH; k++) begin
        chk($sformatf("count%0d", k), 64'(bus.Count[k*WIDTH +: WIDTH]), exp_cnt(k));
        chk($sformatf("tick%0d", k), 64'(bus.Tick[k]), 64'(m_tick[k]));
        chk($sformatf("wrap%0d", k), 64'(bus.Wrap[k]), exp_wrap(k));
      end
    end
  end

  task automatic step(input logic rn, input int slt, input logic en, input logic we,
                      input int dv, input logic cl);
    rst_n      = rn;
    bus.Slt    = SEL_W'(slt);
    bus.En     = en;
    bus.CfgWe  = we;
    bus.CfgDiv = PRE_W'(dv);
    bus.Clr    = cl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] cnt(int k);
    return 64'(bus.Count[k*WIDTH +: WIDTH]);
  endfunction

  initial begin
    logic [7:0] tv;
    step(1'b0, 0, 1'b1, 1'b1, 7, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1, 7, 1'b0);
    chk("rst_count", 64'(bus.Count), 64'd0);
    chk("rst_tick", 64'(bus.Tick), 64'd0);
    chk("rst_wrap", 64'(bus.Wrap), 64'd0);

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
      chk("t1_tick0", 64'(bus.Tick[0]), 64'd1);
    end
    chk("t1_count0", cnt(0), 64'd5);
    chk("t1_count123", 64'(bus.Count[4*WIDTH-1:WIDTH]), 64'd0);

    step(1'b1, 1, 1'b0, 1'b1, 3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
      tv[i] = bus.Tick[1];
    end
    chk("t2_count1", cnt(1), 64'd2);
    chk("t2_tick1_pattern", 64'(tv), 64'h88);

    step(1'b1, 0, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 0, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    chk("t3_count1_hold", cnt(1), 64'd2);
    step(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    chk("t3_count1_inc", cnt(1), 64'd3);
    chk("t3_tick1", 64'(bus.Tick[1]), 64'd1);
    chk("t3_count0", cnt(0), 64'd10);

    for (int i = 0; i < 7; i++) step(1'b1, 3, 1'b1, 1'b0, 0, 1'b0);
    chk("t4_count3_pre", cnt(3), 64'd7);
    step(1'b1, 3, 1'b1, 1'b1, 5, 1'b1);
    chk("t4_count3", cnt(3), 64'd0);
    chk("t4_wrap3", 64'(bus.Wrap[3]), 64'd0);
    chk("t4_tick3", 64'(bus.Tick[3]), 64'd0);
    step(1'b1, 3, 1'b1, 1'b0, 0, 1'b0);
    chk("t4_div3_kept", cnt(3), 64'd1);

    for (int i = 0; i < 255; i++) step(1'b1, 2, 1'b1, 1'b0, 0, 1'b0);
    chk("t5_count2_max", cnt(2), 64'd255);
`ifdef MULTI_COUNTER_SAT_EN
    chk("t5_wrap2_at_max", 64'(bus.Wrap[2]), 64'd1);
    step(1'b1, 2, 1'b1, 1'b0, 0, 1'b0);
    chk("t5_count2_sat", cnt(2), 64'd255);
    chk("t5_tick2_sat", 64'(bus.Tick[2]), 64'd0);
`else
    chk("t5_wrap2_at_max", 64'(bus.Wrap[2]), 64'd0);
    step(1'b1, 2, 1'b1, 1'b0, 0, 1'b0);
    chk("t5_count2_wrap", cnt(2), 64'd0);
`endif
    chk("t5_wrap2_set", 64'(bus.Wrap[2]), 64'd1);
    step(1'b1, 2, 1'b0, 1'b0, 0, 1'b0);
    chk("t5_wrap2_sticky", 64'(bus.Wrap[2]), 64'd1);

    step(1'b1, 1, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 38; i++) step(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    chk("t6_count1_pre", cnt(1), 64'd9);
    step(1'b0, 1, 1'b1, 1'b0, 0, 1'b0);
    chk("t6_rst_count", 64'(bus.Count), 64'd0);
    chk("t6_rst_tick", 64'(bus.Tick), 64'd0);
    chk("t6_rst_wrap", 64'(bus.Wrap), 64'd0);
    step(1'b1, 1, 1'b1, 1'b0, 0, 1'b0);
    chk("t6_div1_zero", cnt(1), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      int r;
      int dv;
      r  = int'($urandom_range(0, 999));
      dv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      step(r > 2, int'($urandom_range(0, CH - 1)), $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 4, dv, $urandom_range(0, 99) < 3);
    end

    step(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
